// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register.
// Manual ops are hold, shift right, shift left and parallel load. An
// autonomous serialise sequence loads d and shifts it out LSB-first.
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN (adds the rotate port).
module shift_reg_univ #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rot_en;
  logic             right_in;
  logic             left_in;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign rot_en = rotate;
`else
  assign rot_en = 1'b0;
`endif

  // Select the bits entering each end: the wrapped-around bit when rotating, else the serial inputs
  always_comb begin
    right_in = sin_r;
    left_in  = sin_l;
    if (rot_en) begin
      right_in = q[0];
      left_in  = q[WIDTH-1];
    end
    shr_val = {right_in, q[WIDTH-1:1]};
    shl_val = {q[WIDTH-2:0], left_in};
  end

  // Single state machine owning the word, the bit counter and the registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q     <= d;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else if (enable) begin
            case (mode)
              MODE_HOLD:  q <= q;
              MODE_RIGHT: q <= shr_val;
              MODE_LEFT:  q <= shl_val;
              MODE_LOAD:  q <= d;
              default:    q <= q;
            endcase
          end
        end
        SHIFT: begin
          if (enable) begin
            q <= shr_val;
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + ONE_CNT;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign q_bar  = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH = 8).
module tb_shift_reg_univ;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin_r;
  logic         sin_l;
  logic         start;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  logic         rotate;
`endif
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         sout_r;
  logic         sout_l;
  logic         busy;
  logic         done;

  int checkCount;
  int passCount;
  int doneSeen;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rotate (rotate),
`endif
    .q      (q),
    .q_bar  (q_bar),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one set of inputs, then step past the next rising edge
  task automatic applyStimulus(input logic en_i, input logic [1:0] mode_i, input logic [W-1:0] d_i,
                               input logic sr_i, input logic sl_i, input logic start_i);
    enable = en_i;
    mode   = mode_i;
    d      = d_i;
    sin_r  = sr_i;
    sin_l  = sl_i;
    start  = start_i;
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with hand-computed expectations
  initial begin
    logic [W-1:0] word;
    checkCount = 0;
    passCount  = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = 2'b00;
    d      = '0;
    sin_r  = 1'b0;
    sin_l  = 1'b0;
    start  = 1'b0;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    rotate = 1'b0;
`endif
    #12;
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_qbar", q_bar, 8'hFF);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_sout_r", sout_r, 1'b0);
    checkOutput("rst_sout_l", sout_l, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Manual operations
    applyStimulus(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("load_q", q, 8'hA5);
    checkOutput("load_qbar", q_bar, 8'h5A);
    checkOutput("load_sout_l", sout_l, 1'b1);
    applyStimulus(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("shr_q", q, 8'hD2);
    checkOutput("shr_sout_r", sout_r, 1'b0);
    applyStimulus(1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("shl_q", q, 8'hA4);
    applyStimulus(1'b0, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_en0_q", q, 8'hA4);
    applyStimulus(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_m00_q", q, 8'hA4);
    checkOutput("idle_busy", busy, 1'b0);

    // Serialise 0x96 without stalls
    word = 8'h96;
    applyStimulus(1'b1, 2'b00, word, 1'b0, 1'b0, 1'b1);
    checkOutput("ser_q_start", q, 8'h96);
    checkOutput("ser_busy_0", busy, 1'b1);
    checkOutput("ser_bit_0", sout_r, word[0]);
    for (int k = 1; k < W; k++) begin
      applyStimulus(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("ser_bit_%0d", k), sout_r, word[k]);
      checkOutput($sformatf("ser_busy_%0d", k), busy, 1'b1);
      checkOutput($sformatf("ser_done_%0d", k), done, 1'b0);
    end
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ser_done_pulse", done, 1'b1);
    checkOutput("ser_busy_end", busy, 1'b0);
    checkOutput("ser_q_final", q, 8'h00);
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ser_done_clear", done, 1'b0);

    // Serialise 0x96 with a three-cycle stall after the third shift, sin_r high
    applyStimulus(1'b1, 2'b00, word, 1'b1, 1'b0, 1'b1);
    checkOutput("stl_bit_0", sout_r, word[0]);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("stl_bit_%0d", k), sout_r, word[k]);
    end
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 2'b11, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("stl_hold_bit_%0d", s), sout_r, word[3]);
      checkOutput($sformatf("stl_hold_busy_%0d", s), busy, 1'b1);
      checkOutput($sformatf("stl_hold_done_%0d", s), done, 1'b0);
    end
    for (int k = 4; k < W; k++) begin
      applyStimulus(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("stl_bit_%0d", k), sout_r, word[k]);
      checkOutput($sformatf("stl_done_%0d", k), done, 1'b0);
    end
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("stl_done_pulse", done, 1'b1);
    checkOutput("stl_q_final", q, 8'hFF);
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("stl_done_clear", done, 1'b0);

    // start has priority over a parallel load; start held through SHIFT and DONE is ignored
    applyStimulus(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b1);
    checkOutput("pri_q", q, 8'h3C);
    checkOutput("pri_busy", busy, 1'b1);
    applyStimulus(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b1);
    checkOutput("pri_norestart_q", q, 8'h1E);
    doneSeen = 0;
    for (int k = 2; k <= W + 3; k++) begin
      applyStimulus(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, (k <= W + 1) ? 1'b1 : 1'b0);
      if (done) doneSeen++;
      if (k == W) checkOutput("pri_done_at_end", done, 1'b1);
    end
    checkOutput("pri_done_count", doneSeen, 1);
    checkOutput("pri_idle_busy", busy, 1'b0);

    // Asynchronous reset in the middle of a sequence
    applyStimulus(1'b1, 2'b00, 8'hFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("ars_pre_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ars_q", q, 8'h00);
    checkOutput("ars_qbar", q_bar, 8'hFF);
    checkOutput("ars_busy", busy, 1'b0);
    checkOutput("ars_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("ars_after_busy", busy, 1'b0);
    checkOutput("ars_after_q", q, 8'h00);
    applyStimulus(1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
    checkOutput("ars_idle_load", q, 8'h5A);

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // Rotate-mode serialise restores the word; manual left rotate wraps the MSB
    rotate = 1'b1;
    applyStimulus(1'b1, 2'b00, 8'h81, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= W; k++) begin
      applyStimulus(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("rot_ser_done", done, 1'b1);
    checkOutput("rot_ser_q", q, 8'h81);
    applyStimulus(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rot_left_q", q, 8'h03);
    rotate = 1'b0;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the registered, multi-bit successor of the team's gate-level D latch. It holds a WIDTH-bit word with true and complement outputs, supports hold / shift-right / shift-left / parallel-load under a mode select, and adds an autonomous serialise sequence (load, then shift out WIDTH bits LSB-first with busy/done status). It sits between parallel datapath logic and serial links or scan-style chains.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  qualifies manual operations; stalls the serialise sequence when low.
- mode  input  2  manual op: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load / serialise source word.
- sin_r  input  1  serial input entering the MSB on a right shift.
- sin_l  input  1  serial input entering the LSB on a left shift.
- start  input  1  launches the serialise sequence; sampled in IDLE only.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  bitwise complement of q, always.
- sout_r  output  1  q[0].
- sout_l  output  1  q[WIDTH-1].
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle pulse in DONE state.
- rotate  input  1  present only with SHIFT_REG_UNIV_ROTATE_EN (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE. Internal counter cnt, width $clog2(WIDTH).
- Reset (rst_n low, asynchronous, any state): q = 0, q_bar = all ones, sout_r = sout_l = 0, busy = 0, done = 0, cnt = 0, state IDLE. Takes effect immediately and aborts any sequence.
- IDLE, start = 1: q <= d, cnt <= 0, go SHIFT. start has priority over enable/mode in the same cycle.
- IDLE, start = 0, enable = 1: mode 00 hold; 01 q <= {sin_r, q[WIDTH-1:1]}; 10 q <= {q[WIDTH-2:0], sin_l}; 11 q <= d.
- IDLE, start = 0, enable = 0: hold.
- SHIFT, enable = 1: right shift with sin_r; cnt <= cnt+1; when cnt == WIDTH-1 at the edge, cnt <= 0 and go DONE.
- SHIFT, enable = 0: q, cnt, state all hold (stall); busy stays high.
- DONE: done = 1 for exactly one cycle; q holds; unconditionally return to IDLE.
- start, mode, enable are ignored in DONE; start and mode are ignored in SHIFT.
- q_bar, sout_r and sout_l are combinational from q; no other output depends combinationally on inputs.

## Timing
- Manual ops: one-cycle latency; the result is visible on q after the capturing edge.
- Serialise, no stalls: start sampled at edge E0. After E0, state is SHIFT, q = d, sout_r = d[0]. After edge Ek (k = 1..WIDTH-1), sout_r = d[k]. Edge E_WIDTH enters DONE, so done is high for the cycle after E_WIDTH. Edge E_WIDTH+1 returns to IDLE. The earliest accepted next start is at E_WIDTH+1.
- Each low-enable cycle in SHIFT extends the sequence by exactly one cycle.
- Final q after serialise equals d shifted right WIDTH times with sin_r values (unrotated).

## Configuration
- SHIFT_REG_UNIV_ROTATE_EN defined: port rotate exists. When rotate = 1, right shifts (manual and serialise) insert q[0] at the MSB and left shifts insert q[WIDTH-1] at the LSB; sin_r and sin_l are ignored. After a rotate-mode serialise, q equals the original d.
- Not defined: no rotate port; behaviour is identical to rotate = 0.

## Test plan
- Reset: drive rst_n low mid-SHIFT with WIDTH=8 -> q=0x00, q_bar=0xFF, busy=0, done=0 immediately, without waiting for a clock edge; after release, state is IDLE.
- Manual ops: load 0xA5 -> q=0xA5, q_bar=0x5A. Shift right with sin_r=1 -> 0xD2. Shift left with sin_l=0 -> 0xA4. Hold with enable=0 -> 0xA4.
- Serialise: d=0x96, start, enable=1 -> sout_r shows 0,1,1,0,1,0,0,1 on 8 consecutive cycles; done pulses once, 9 cycles after start; busy is high for 8 cycles.
- Stall: repeat with enable low for 3 cycles mid-SHIFT -> same bit sequence with 3 held cycles; done is delayed by exactly 3 cycles.
- Priority/ignore: start=1 with mode=11, d=0x3C in IDLE -> sequence launches with q=0x3C. start pulsed during SHIFT -> no restart and no second done.
- With SHIFT_REG_UNIV_ROTATE_EN, rotate=1, d=0x81 serialise -> final q=0x81. A manual left rotate of 0x81 -> 0x03.
